multiplier_seq: RTL and testbench

Parametrised, iterative integer multiplier with a start/done handshake. It is the successor of the single-width multiplier wrapper in the ALU's multi-cycle path. It takes WIDTH-bit operands, runs a signed or unsigned shift-add sequence at one partial product per cycle, and returns both the WIDTH-bit result and the full 2·WIDTH-bit product. Overflow is flagged against the WIDTH-bit result in the selected mode. The processor's multdiv stage issues operations to it and stalls on `busy`.

---
 rtl/multiplier_seq.sv | 121 ++++++++++++
 tb/tb_multiplier_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, signed or unsigned.
// Operates on magnitudes and applies the sign in a final fix-up cycle.
module multiplier_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0] product_full
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               signed_q, signed_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] full_q, full_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] mag, res;

    assign a_neg = is_signed & inA[WIDTH-1];
    assign b_neg = is_signed & inB[WIDTH-1];
    assign mag   = acc_q[2*WIDTH-1:0];
    // -0 is still 0, so a zero product is never reported as negative.
    assign res   = neg_q ? ('0 - mag) : mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        full_d    = full_q;
        upper_sum = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    signed_d = is_signed;
                    neg_d    = a_neg ^ b_neg;
                    // -2^(W-1) negates to itself, which read unsigned is its magnitude.
                    mcand_d  = a_neg ? ('0 - inA) : inA;
                    mplier_d = b_neg ? ('0 - inB) : inB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                full_d  = res;
                ovf_d   = signed_q ? ~((&res[2*WIDTH-1:WIDTH-1]) | ~(|res[2*WIDTH-1:WIDTH-1]))
                                   : (|res[2*WIDTH-1:WIDTH]);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            full_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            signed_q <= signed_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            full_q   <= full_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign product      = full_q[WIDTH-1:0];
    assign product_full = full_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed and randomised checks of multiplier_seq at WIDTH=32 and WIDTH=8.
module tb_multiplier_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, ovf32;
    logic [31:0] p32;
    logic [63:0] pf32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, ovf8;
    logic [7:0]  p8;
    logic [15:0] pf8;

    int n_checks = 0;
    int n_errors = 0;

    multiplier_seq #(.WIDTH(32)) u_dut32 (
        .clock(clk), .reset(rst_n), .start(start32), .is_signed(sgn32),
        .inA(a32), .inB(b32), .busy(busy32), .done(done32), .overflow(ovf32),
        .product(p32), .product_full(pf32)
    );

    multiplier_seq #(.WIDTH(8)) u_dut8 (
        .clock(clk), .reset(rst_n), .start(start8), .is_signed(sgn8),
        .inA(a8), .inB(b8), .busy(busy8), .done(done8), .overflow(ovf8),
        .product(p8), .product_full(pf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    // Caller is at a falling edge; returns at the falling edge after the sampling edge.
    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s);
        a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sgn32 = ~s;
        check("busy32_after_start", busy32, 1);
    endtask

    task automatic wait32(output int edges);
        edges = 0;
        while (!done32 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("done32_seen", done32, 1);
        check("busy32_low_with_done", busy32, 0);
    endtask

    task automatic res32(input string tag, input logic [63:0] exp_pf, input logic exp_ov);
        check({tag, "_pf"}, pf32, exp_pf);
        check({tag, "_p"}, p32, exp_pf[31:0]);
        check({tag, "_ov"}, ovf32, exp_ov);
    endtask

    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_pf, input logic exp_ov);
        int e;
        go32(a, b, s);
        wait32(e);
        check({tag, "_lat"}, e, 33);
        res32(tag, exp_pf, exp_ov);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp_pf, input logic exp_ov);
        int e;
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; sgn8 = ~s;
        e = 0;
        while (!done8 && e < 30) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        check({tag, "_lat"}, e, 9);
        check({tag, "_pf"}, pf8, exp_pf);
        check({tag, "_p"}, p8, exp_pf[7:0]);
        check({tag, "_ov"}, ovf8, exp_ov);
    endtask

    initial begin
        int e;
        int dones;
        logic [31:0] ra, rb;
        logic [7:0]  qa, qb;
        logic        rs;
        logic [63:0] m32;
        logic [15:0] m8;

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_ov", ovf32, 0);
        check("rst_pf", pf32, 0);
        check("rst_pf8", pf8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        op32("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        op32("smin_x1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        op32("smin_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b1);
        op32("u_ff_x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b1);
        op32("s_m1_x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        op32("s_0_xm5", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'h0, 1'b0);

        // Start pulsed mid-run must be ignored.
        go32(32'd100, 32'd200, 1'b0);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        a32 = 32'd9; b32 = 32'd9; sgn32 = 1'b1; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        wait32(e);
        check("ign_lat", e, 23);
        res32("ign", 64'd20000, 1'b0);

        // Back-to-back start in the done cycle.
        go32(32'd3, 32'd5, 1'b0);
        check("hold_pf", pf32, 64'd20000);
        wait32(e);
        check("b2b_lat", e, 33);
        res32("b2b", 64'd15, 1'b0);

        // Reset during the run clears everything at once.
        go32(32'd11, 32'd13, 1'b0);
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy32, 0);
        check("arst_done", done32, 0);
        check("arst_ov", ovf32, 0);
        check("arst_p", p32, 0);
        check("arst_pf", pf32, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || busy32) dones++;
        end
        check("abort_no_done", dones, 0);
        op32("post_rst", 32'd6, 32'd7, 1'b0, 64'd42, 1'b0);

        op8("u100x100", 8'd100, 8'd100, 1'b0, 16'h2710, 1'b1);
        op8("s_m128_m1", 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1);
        op8("s_m128_x1", 8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);

        for (int i = 0; i < 300; i++) begin
            qa = 8'($urandom);
            qb = 8'($urandom);
            rs = 1'($urandom);
            m8 = model8(qa, qb, rs);
            op8("rnd8", qa, qb, rs, m8,
                rs ? ~((&m8[15:7]) | ~(|m8[15:7])) : (|m8[15:8]));
        end

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            rs = 1'($urandom);
            m32 = model32(ra, rb, rs);
            op32("rnd32", ra, rb, rs, m32,
                 rs ? ~((&m32[63:31]) | ~(|m32[63:31])) : (|m32[63:32]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
